// File: rtl/pcie_reg_axil_responder.sv
// AXI4-Lite register bank: four scratch registers, ID, completed-write
// counter and an 8-bit interrupt status/enable pair driving a level irq.
// Write and read channels run independent two-state FSMs.
module pcie_reg_axil_responder #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] C_ID_VALUE         = 32'h5052_0100
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  input  logic [7:0]                        irq_src,
  output logic                              irq
);

  localparam int          DW          = C_S_AXI_DATA_WIDTH;
  localparam int          STRB_W      = DW / 8;
  localparam int          IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
  typedef enum logic { RD_IDLE, RD_RESP } rd_state_t;

  wr_state_t             wr_state, wr_state_next;
  rd_state_t             rd_state, rd_state_next;

  logic                  aw_done, w_done;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DW-1:0]         w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, b_hs, wr_commit, wr_unmapped;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DW-1:0]         wr_data, rd_mux_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [1:0]            rd_mux_resp;

  logic [DW-1:0]         scratch [4];
  logic [DW-1:0]         wr_count;
  logic [7:0]            irq_status, irq_enable;
  logic [7:0]            status_next, enable_next;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write control: pick live or captured AW/W and decide when the write commits.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    wr_state_next = wr_state;
    wr_commit     = 1'b0;
    aw_hs         = s_axi_awvalid & s_axi_awready;
    w_hs          = s_axi_wvalid & s_axi_wready;
    b_hs          = s_axi_bvalid & s_axi_bready;
    wr_idx        = aw_done ? aw_idx_q : s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    wr_data       = w_done ? w_data_q : s_axi_wdata;
    wr_strb       = w_done ? w_strb_q : s_axi_wstrb;
    wr_unmapped   = 32'(wr_idx) > 7;
    case (wr_state)
      WR_IDLE: if ((aw_done | aw_hs) & (w_done | w_hs)) begin
        wr_commit     = 1'b1;
        wr_state_next = WR_RESP;
      end
      WR_RESP: if (b_hs) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_next;
  end

  // Write channel handshakes, AW/W captures and the registered response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_commit) begin
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_unmapped ? RESP_SLVERR : RESP_OKAY;
          end else begin
            if (aw_hs) begin
              aw_done  <= 1'b1;
              aw_idx_q <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_done   <= 1'b1;
              w_data_q <= s_axi_wdata;
              w_strb_q <= s_axi_wstrb;
            end
            s_axi_awready <= ~(aw_done | aw_hs);
            s_axi_wready  <= ~(w_done | w_hs);
          end
        end
        WR_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Interrupt next state: W1C clear first, then any raised source wins.
  always_comb begin
    status_next = irq_status;
    enable_next = irq_enable;
    if (wr_commit && wr_strb[0] && 32'(wr_idx) == 6) status_next = irq_status & ~wr_data[7:0];
    if (wr_commit && wr_strb[0] && 32'(wr_idx) == 7) enable_next = wr_data[7:0];
    status_next = status_next | irq_src;
  end

  // Register bank, completed-write counter and registered interrupt.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      // NOTE: the scratch array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      wr_count   <= '0;
      irq_status <= '0;
      irq_enable <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_commit && 32'(wr_idx) < 4) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) scratch[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      if (b_hs && s_axi_bresp == RESP_OKAY) wr_count <= wr_count + 1'b1;
      irq_status <= status_next;
      irq_enable <= enable_next;
      irq        <= |(status_next & enable_next);
    end
  end

  // Read control and register read multiplexer.
  always_comb begin
    rd_state_next = rd_state;
    ar_hs         = s_axi_arvalid & s_axi_arready;
    rd_idx        = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_mux_data   = '0;
    rd_mux_resp   = RESP_OKAY;
    if (32'(rd_idx) > 7) begin
      rd_mux_resp = RESP_SLVERR;
    end else begin
      case (rd_idx[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: rd_mux_data = scratch[rd_idx[1:0]];
        3'd4:    rd_mux_data = C_ID_VALUE[DW-1:0];
        3'd5:    rd_mux_data = wr_count;
        3'd6:    rd_mux_data = {{(DW-8){1'b0}}, irq_status};
        default: rd_mux_data = {{(DW-8){1'b0}}, irq_enable};
      endcase
    end
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_state_next = RD_RESP;
      RD_RESP: if (s_axi_rvalid & s_axi_rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_next;
  end

  // Read channel handshake and registered read data/response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_mux_data;
            s_axi_rresp   <= rd_mux_resp;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        RD_RESP: if (s_axi_rready) begin
          s_axi_rvalid  <= 1'b0;
          s_axi_arready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_reg_axil_responder.sv
// Self-checking bench for pcie_reg_axil_responder: directed register-map,
// strobe, interrupt, backpressure and reset cases followed by randomized
// accesses compared against a register-level reference model.
module tb_pcie_reg_axil_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [5:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  irq_src;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the architectural registers.
  logic [31:0] m_scratch [4];
  logic [31:0] m_count;
  logic [7:0]  m_status;
  logic [7:0]  m_enable;

  pcie_reg_axil_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .irq_src(irq_src), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [5:0] a);
    return (a >= 6'h20) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [5:0] a);
    int word = int'(a) / 4;
    if (word < 4)  return m_scratch[word];
    if (word == 4) return 32'h5052_0100;
    if (word == 5) return m_count;
    if (word == 6) return {24'h0, m_status};
    if (word == 7) return {24'h0, m_enable};
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_scratch[i] = 32'h0;
    m_count  = 32'h0;
    m_status = 8'h0;
    m_enable = 8'h0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [7:0] src);
    int word = int'(a) / 4;
    if (word < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_scratch[word][8*b +: 8] = d[8*b +: 8];
    end
    if (word == 6 && s[0]) m_status = m_status & ~d[7:0];
    if (word == 7 && s[0]) m_enable = d[7:0];
    m_status = m_status | src;
  endtask

  // Write with W presented w_lead cycles ahead of AW; src pulses irq_src on
  // the commit edge; bdelay cycles of bready=0 with a second AW held pending.
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input logic [7:0] src, input int bdelay);
    bit aw_ok = 0, w_ok = 0, aw_sent, aw_f, w_f;
    int cyc = 0;
    logic [1:0] exp_resp = model_resp(a);
    aw_sent       = (w_lead == 0);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = aw_sent;
    s_axi_wvalid  = 1'b1;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f  = s_axi_wvalid && s_axi_wready;
      if ((aw_ok || aw_f) && (w_ok || w_f)) irq_src = src;
      @(negedge ACLK);
      cyc++;
      irq_src = 8'h0;
      if (aw_f) begin aw_ok = 1; s_axi_awvalid = 1'b0; end
      if (w_f)  begin w_ok  = 1; s_axi_wvalid  = 1'b0; end
      if (!aw_sent && cyc >= w_lead) begin s_axi_awvalid = 1'b1; aw_sent = 1; end
      if (!(aw_ok && w_ok)) check("bvalid_before_commit", 32'(s_axi_bvalid), 32'h0);
    end
    check("aw_w_handshake", 32'(aw_ok && w_ok), 32'h1);
    if (!(aw_ok && w_ok)) begin
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      return;
    end
    model_write(a, d, s, src);
    check("bvalid_after_commit", 32'(s_axi_bvalid), 32'h1);
    check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    if (bdelay > 0) begin
      s_axi_awvalid = 1'b1;
      repeat (bdelay) begin
        @(negedge ACLK);
        check("bvalid_held", 32'(s_axi_bvalid), 32'h1);
        check("bresp_held", 32'(s_axi_bresp), 32'(exp_resp));
        check("awready_in_resp", 32'(s_axi_awready), 32'h0);
        check("wready_in_resp", 32'(s_axi_wready), 32'h0);
      end
      s_axi_awvalid = 1'b0;
    end
    s_axi_bready = 1'b1;
    @(negedge ACLK);
    s_axi_bready = 1'b0;
    if (exp_resp == 2'b00) m_count = m_count + 1;
    check("bvalid_cleared", 32'(s_axi_bvalid), 32'h0);
    check("awready_reopened", 32'(s_axi_awready), 32'h1);
  endtask

  task automatic do_read(input logic [5:0] a, input int rdelay, output logic [31:0] got);
    bit ok = 0, f;
    int cyc = 0;
    logic [31:0] exp_d = 32'h0;
    logic [1:0]  exp_r = 2'b00;
    got           = 32'hx;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    while (!ok && cyc < 40) begin
      f = s_axi_arvalid && s_axi_arready;
      if (f) begin exp_d = model_rdata(a); exp_r = model_resp(a); end
      @(negedge ACLK);
      cyc++;
      if (f) begin ok = 1; s_axi_arvalid = 1'b0; end
    end
    check("ar_handshake", 32'(ok), 32'h1);
    if (!ok) begin s_axi_arvalid = 1'b0; return; end
    check("rvalid", 32'(s_axi_rvalid), 32'h1);
    check("rdata", s_axi_rdata, exp_d);
    check("rresp", 32'(s_axi_rresp), 32'(exp_r));
    got = s_axi_rdata;
    repeat (rdelay) begin
      @(negedge ACLK);
      check("rvalid_held", 32'(s_axi_rvalid), 32'h1);
      check("rdata_held", s_axi_rdata, exp_d);
      check("arready_in_resp", 32'(s_axi_arready), 32'h0);
    end
    s_axi_rready = 1'b1;
    @(negedge ACLK);
    s_axi_rready = 1'b0;
    check("rvalid_cleared", 32'(s_axi_rvalid), 32'h0);
    check("arready_reopened", 32'(s_axi_arready), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    irq_src = 8'h0;
    model_reset();

    // Reset state, then readys rise on the first edge after release.
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(s_axi_awready), 32'h0);
    check("rst_wready", 32'(s_axi_wready), 32'h0);
    check("rst_arready", 32'(s_axi_arready), 32'h0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_bresp", 32'(s_axi_bresp), 32'h0);
    check("rst_rresp", 32'(s_axi_rresp), 32'h0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rel_awready", 32'(s_axi_awready), 32'h1);
    check("rel_wready", 32'(s_axi_wready), 32'h1);
    check("rel_arready", 32'(s_axi_arready), 32'h1);

    // Scratch write/readback and write counter.
    for (int i = 0; i < 4; i++) do_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 8'h0, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(6'(4 * i), 0, rd);
      check("scratch_readback", rd, 32'(i + 1));
    end
    do_read(6'h14, 0, rd);
    check("wr_count_4", rd, 32'd4);

    // W three cycles ahead of AW with a single-byte strobe.
    do_write(6'h00, 32'h1122_3344, 4'hF, 0, 8'h0, 0);
    do_write(6'h00, 32'hAABB_CCDD, 4'b0010, 3, 8'h0, 0);
    do_read(6'h00, 0, rd);
    check("scratch0_strobe", rd, 32'h1122_CC44);

    // ID register and unmapped access.
    do_read(6'h10, 0, rd);
    check("id_value", rd, 32'h5052_0100);
    do_write(6'h24, 32'hFFFF_FFFF, 4'hF, 1, 8'h0, 0);
    do_read(6'h24, 0, rd);
    do_read(6'h14, 0, rd);
    check("wr_count_after_slverr", rd, 32'd6);

    // Interrupts: enable bit 0, pulse source, W1C racing a set, clean W1C.
    do_write(6'h1C, 32'h0000_0001, 4'b0001, 0, 8'h0, 0);
    check("irq_before_pulse", 32'(irq), 32'h0);
    irq_src = 8'h01;
    @(negedge ACLK);
    irq_src = 8'h00;
    m_status = m_status | 8'h01;
    check("irq_after_pulse", 32'(irq), 32'h1);
    do_read(6'h18, 0, rd);
    check("status_after_pulse", rd, 32'h1);
    do_write(6'h18, 32'h0000_0001, 4'b0001, 0, 8'h01, 0);
    do_read(6'h18, 0, rd);
    check("status_set_wins", rd, 32'h1);
    check("irq_set_wins", 32'(irq), 32'h1);
    do_write(6'h18, 32'h0000_0001, 4'b0001, 0, 8'h0, 0);
    do_read(6'h18, 0, rd);
    check("status_cleared", rd, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // Backpressure on both response channels for 10 cycles.
    fork
      do_write(6'h08, 32'hCAFE_F00D, 4'hF, 0, 8'h0, 10);
      begin
        logic [31:0] rd_bp;
        do_read(6'h04, 10, rd_bp);
      end
    join
    do_read(6'h08, 0, rd);
    do_read(6'h14, 0, rd);

    // Randomized accesses against the model.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] ra = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] src = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
        do_write(ra, $urandom, 4'($urandom), int'($urandom_range(0, 2)), src, 0);
        check("rand_irq", 32'(irq), 32'(|(m_status & m_enable)));
      end else begin
        do_read(ra, 0, rd);
      end
    end

    // Reset while a write response is pending.
    s_axi_awaddr = 6'h00; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge ACLK);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("pre_reset_bvalid", 32'(s_axi_bvalid), 32'h1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_rst_bvalid", 32'(s_axi_bvalid), 32'h0);
    check("mid_rst_awready", 32'(s_axi_awready), 32'h0);
    check("mid_rst_wready", 32'(s_axi_wready), 32'h0);
    check("mid_rst_arready", 32'(s_axi_arready), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    ARESET = 1'b0;
    model_reset();
    @(negedge ACLK);
    check("post_rst_awready", 32'(s_axi_awready), 32'h1);
    check("post_rst_arready", 32'(s_axi_arready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      do_read(6'(4 * i), 0, rd);
      check("scratch_after_reset", rd, 32'h0);
    end
    do_read(6'h14, 0, rd);
    check("wr_count_after_reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
